// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the byte-addressed data memory.
package data_memory_pkg;
  typedef enum logic [1:0] {
    BYTE     = 2'd0,
    HALF     = 2'd1,
    WORD     = 2'd2,
    RESERVED = 2'd3
  } access_size_t;

  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t WAIT    = 2'd1;
  localparam state_t RESPOND = 2'd2;

  // Reserved size counts as misaligned so one flag drives the error path.
  function automatic logic is_misaligned(input access_size_t size, input logic [1:0] addr);
    case (size)
      BYTE:    return 1'b0;
      HALF:    return addr[0];
      WORD:    return |addr;
      default: return 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/data_memory_byte_lane_ram.sv
// Word-organised storage with per-byte write enables and combinational read.
module byte_lane_ram #(
  parameter int NUM_WORDS = 4,
  parameter int ADDR_W    = 2
) (
  input  logic              clock,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] word_address,
  input  logic [3:0]        byte_enable,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data
);
  logic [31:0] mem [NUM_WORDS];

  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (write_enable && byte_enable[i]) mem[word_address][i*8 +: 8] <= write_data[i*8 +: 8];
    end
  end

  assign read_data = mem[word_address];
endmodule

// File: rtl/data_memory.sv
// Load/store front end: handshake FSM, wait-state counter, lane steering and extension.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int NUM_BYTES   = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         request_valid,
  output logic                         request_ready,
  input  logic                         request_write,
  input  logic [$clog2(NUM_BYTES)-1:0] request_address,
  input  logic [1:0]                   request_size,
  input  logic                         request_unsigned,
  input  logic [31:0]                  request_write_data,
  output logic                         response_valid,
  input  logic                         response_ready,
  output logic [31:0]                  response_read_data,
  output logic                         response_error
);
  localparam int AW = $clog2(NUM_BYTES);
  localparam int WW = (NUM_BYTES > 4) ? AW - 2 : 1;

  state_t       state;
  logic [3:0]   count;
  logic         cap_write, cap_unsigned;
  logic [AW-1:0] cap_address;
  access_size_t cap_size;
  logic [31:0]  cap_write_data;

  logic         accept, enter_respond, misaligned, write_enable;
  logic         cur_write, cur_unsigned;
  logic [AW-1:0] cur_address;
  access_size_t cur_size;
  logic [31:0]  cur_write_data;
  logic [1:0]   lane;
  logic [WW-1:0] word_address;
  logic [3:0]   byte_enable;
  logic [31:0]  lane_write_data, read_word, shifted, extended;

  assign request_ready  = (state == IDLE);
  assign response_valid = (state == RESPOND);
  assign accept         = request_valid && request_ready;
  assign enter_respond  = (state == IDLE && accept && WAIT_STATES == 0) ||
                          (state == WAIT && count == 4'd0);

  // With no wait states the access happens on the accept edge, before capture.
  assign cur_write      = (state == IDLE) ? request_write      : cap_write;
  assign cur_unsigned   = (state == IDLE) ? request_unsigned   : cap_unsigned;
  assign cur_address    = (state == IDLE) ? request_address    : cap_address;
  assign cur_size       = (state == IDLE) ? access_size_t'(request_size) : cap_size;
  assign cur_write_data = (state == IDLE) ? request_write_data : cap_write_data;

  assign lane       = cur_address[1:0];
  assign misaligned = is_misaligned(cur_size, lane);

  generate
    if (NUM_BYTES > 4) begin : g_word_addr
      assign word_address = cur_address[AW-1:2];
    end else begin : g_single_word
      assign word_address = '0;
    end
  endgenerate

  always_comb begin
    byte_enable = 4'b0000;
    case (cur_size)
      BYTE:    byte_enable = 4'b0001 << lane;
      HALF:    byte_enable = 4'b0011 << lane;
      WORD:    byte_enable = 4'b1111;
      default: byte_enable = 4'b0000;
    endcase
  end

  assign lane_write_data = cur_write_data << {lane, 3'b000};
  assign write_enable    = enter_respond && cur_write && !misaligned && reset_n;
  assign shifted         = read_word >> {lane, 3'b000};

  always_comb begin
    extended = shifted;
    case (cur_size)
      BYTE:    extended = cur_unsigned ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      HALF:    extended = cur_unsigned ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: extended = shifted;
    endcase
  end

  byte_lane_ram #(.NUM_WORDS(NUM_BYTES / 4), .ADDR_W(WW)) u_ram (
    .clock        (clock),
    .write_enable (write_enable),
    .word_address (word_address),
    .byte_enable  (byte_enable),
    .write_data   (lane_write_data),
    .read_data    (read_word)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      count              <= '0;
      cap_write          <= 1'b0;
      cap_unsigned       <= 1'b0;
      cap_address        <= '0;
      cap_size           <= BYTE;
      cap_write_data     <= '0;
      response_read_data <= '0;
      response_error     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cap_write      <= request_write;
          cap_unsigned   <= request_unsigned;
          cap_address    <= request_address;
          cap_size       <= access_size_t'(request_size);
          cap_write_data <= request_write_data;
          if (WAIT_STATES == 0) state <= RESPOND;
          else begin
            state <= WAIT;
            count <= 4'(WAIT_STATES - 1);
          end
        end
        WAIT: if (count == 4'd0) state <= RESPOND;
              else count <= count - 4'd1;
        RESPOND: if (response_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_respond) begin
        response_error     <= misaligned;
        response_read_data <= (misaligned || cur_write) ? 32'd0 : extended;
      end
    end
  end
endmodule

// File: tb/tb_data_memory.sv
// Randomized + directed bench: two instances (0 and 3 wait states) against a byte-array model.
module tb_data_memory;
  localparam int WS [2] = '{0, 3};

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [3:0]  req_addr  [2];
  logic [1:0]  req_size  [2];
  logic        req_uns   [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data  [2];
  logic        rsp_err   [2];

  logic [7:0]  model [2][16];
  int          tests = 0, fails = 0;

  always #5 clock = ~clock;

  data_memory #(.NUM_BYTES(16), .WAIT_STATES(0)) u_ws0 (
    .clock(clock), .reset_n(reset_n),
    .request_valid(req_valid[0]), .request_ready(req_ready[0]), .request_write(req_write[0]),
    .request_address(req_addr[0]), .request_size(req_size[0]), .request_unsigned(req_uns[0]),
    .request_write_data(req_wdata[0]), .response_valid(rsp_valid[0]), .response_ready(rsp_ready[0]),
    .response_read_data(rsp_data[0]), .response_error(rsp_err[0]));

  data_memory #(.NUM_BYTES(16), .WAIT_STATES(3)) u_ws3 (
    .clock(clock), .reset_n(reset_n),
    .request_valid(req_valid[1]), .request_ready(req_ready[1]), .request_write(req_write[1]),
    .request_address(req_addr[1]), .request_size(req_size[1]), .request_unsigned(req_uns[1]),
    .request_write_data(req_wdata[1]), .response_valid(rsp_valid[1]), .response_ready(rsp_ready[1]),
    .response_read_data(rsp_data[1]), .response_error(rsp_err[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: access is a sequence of nb little-endian bytes starting at a.
  task automatic model_access(input int d, input bit wr, input int a, input int sz, input bit uns,
                              input logic [31:0] wd, output logic [31:0] exp, output logic exp_err);
    int nb;
    logic [31:0] v;
    nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    exp = 32'd0;
    exp_err = (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
    if (exp_err) return;
    if (wr) begin
      for (int i = 0; i < nb; i++) model[d][a+i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v = v | (32'(model[d][a+i]) << (8*i));
      if (nb < 4 && !uns && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      exp = v;
    end
  endtask

  task automatic xact(input int d, input bit wr, input logic [3:0] a, input logic [1:0] sz,
                      input bit uns, input logic [31:0] wd, input int hold,
                      output logic [31:0] got, output logic got_err);
    logic [31:0] exp;
    logic exp_err;
    int lat;
    model_access(d, wr, int'(a), int'(sz), uns, wd, exp, exp_err);
    @(negedge clock);
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = a;
    req_size[d] = sz; req_uns[d] = uns; req_wdata[d] = wd;
    chk("ready_idle", 32'(req_ready[d]), 32'd1);
    @(posedge clock); #1;
    // Scramble the request bus to confirm it is captured, not sampled late.
    req_valid[d] = 1'b0; req_write[d] = ~wr; req_addr[d] = 4'($urandom);
    req_size[d] = 2'($urandom); req_uns[d] = ~uns; req_wdata[d] = $urandom;
    lat = 1;
    while (!rsp_valid[d] && lat < 40) begin
      @(posedge clock); #1; lat++;
    end
    chk("latency", 32'(lat), 32'(WS[d] + 1));
    got = rsp_data[d];
    got_err = rsp_err[d];
    chk("error", 32'(rsp_err[d]), 32'(exp_err));
    chk("data", rsp_data[d], exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_data", rsp_data[d], exp);
      chk("hold_ready", 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clock); #1;
    rsp_ready[d] = 1'b0;
    chk("drain_valid", 32'(rsp_valid[d]), 32'd0);
    chk("drain_ready", 32'(req_ready[d]), 32'd1);
  endtask

  logic [31:0] g;
  logic        ge;

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_write[d] = 0; req_addr[d] = 0; req_size[d] = 0;
      req_uns[d] = 0; req_wdata[d] = 0; rsp_ready[d] = 0;
    end
    repeat (2) @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 32'(req_ready[d]), 32'd1);
      chk("rst_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_data", rsp_data[d], 32'd0);
      chk("rst_err", 32'(rsp_err[d]), 32'd0);
    end
    @(negedge clock) reset_n = 1'b1;

    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 4; w++) xact(d, 1, 4'(w*4), 2'd2, 0, $urandom, 0, g, ge);
      // Word store/load round trip.
      xact(d, 1, 4'h4, 2'd2, 0, 32'hDEADBEEF, 0, g, ge);
      xact(d, 0, 4'h4, 2'd2, 0, 32'd0, 0, g, ge);
      chk("lw_dead", g, 32'hDEADBEEF);
      // Byte store, signed/unsigned byte loads.
      xact(d, 1, 4'h5, 2'd0, 0, 32'h0000_0080, 0, g, ge);
      xact(d, 0, 4'h5, 2'd0, 0, 32'd0, 0, g, ge);
      chk("lb", g, 32'hFFFFFF80);
      xact(d, 0, 4'h5, 2'd0, 1, 32'd0, 0, g, ge);
      chk("lbu", g, 32'h00000080);
      xact(d, 0, 4'h4, 2'd2, 1, 32'd0, 0, g, ge);
      chk("lw_merge", g, 32'hDEAD80EF);
      // Half store into upper lanes, misaligned half load.
      xact(d, 1, 4'h0, 2'd2, 0, 32'hAAAAAAAA, 0, g, ge);
      xact(d, 1, 4'h2, 2'd1, 0, 32'h0000_1234, 0, g, ge);
      xact(d, 0, 4'h0, 2'd2, 0, 32'd0, 0, g, ge);
      chk("sh_merge", g, 32'h1234AAAA);
      xact(d, 0, 4'h1, 2'd1, 0, 32'd0, 0, g, ge);
      chk("lh_mis_err", 32'(ge), 32'd1);
      // Misaligned word store must not touch storage; reserved size errors.
      xact(d, 1, 4'h6, 2'd2, 0, 32'h55555555, 0, g, ge);
      chk("sw_mis_err", 32'(ge), 32'd1);
      xact(d, 0, 4'h4, 2'd2, 0, 32'd0, 0, g, ge);
      chk("lw_unchanged", g, 32'hDEAD80EF);
      xact(d, 0, 4'h8, 2'd3, 0, 32'd0, 0, g, ge);
      chk("size3_err", 32'(ge), 32'd1);
      // Response back-pressure.
      xact(d, 0, 4'h4, 2'd1, 0, 32'd0, 5, g, ge);
    end

    // Reset in the middle of a stalled store on the wait-state instance.
    @(negedge clock);
    req_valid[1] = 1; req_write[1] = 1; req_addr[1] = 4'h8; req_size[1] = 2'd2;
    req_uns[1] = 0; req_wdata[1] = 32'h11223344;
    @(posedge clock); #1;
    req_valid[1] = 0;
    @(posedge clock); #1;
    chk("mid_wait_ready", 32'(req_ready[1]), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("abort_valid", 32'(rsp_valid[1]), 32'd0);
    chk("abort_ready", 32'(req_ready[1]), 32'd1);
    chk("abort_data", rsp_data[1], 32'd0);
    chk("abort_err", 32'(rsp_err[1]), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    xact(1, 0, 4'h8, 2'd2, 0, 32'd0, 0, g, ge);

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 80; n++)
        xact(d, 1'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), $urandom,
             int'($urandom_range(0, 2)), g, ge);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
